// File: rtl/dual_priority_pkg.sv
// Shared constants, channel state encoding and code decode for the dual-grant arbiter.
package dual_priority_pkg;
  localparam int N_REQ  = 12;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_BUSY = 2'd1,
    CH_GAP  = 2'd2
  } ch_state_e;

  // code k+1 -> bit k; code 0 (or out of range) -> all zero
  function automatic logic [N_REQ-1:0] code2onehot(input logic [CODE_W-1:0] code);
    logic [N_REQ-1:0] oh;
    oh = '0;
    for (int k = 0; k < N_REQ; k++)
      if (code == CODE_W'(k + 1)) oh[k] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/rr_dual_pick.sv
// Round-robin scan from ptr upward (wrapping) returning the first and second set candidates.
module rr_dual_pick
  import dual_priority_pkg::*;
(
  input  logic [N_REQ-1:0]  cand,
  input  logic [CODE_W-1:0] ptr,
  output logic              first_vld,
  output logic [CODE_W-1:0] first_idx,
  output logic              second_vld,
  output logic [CODE_W-1:0] second_idx
);
  always_comb begin
    first_vld  = 1'b0;
    first_idx  = '0;
    second_vld = 1'b0;
    second_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      logic [CODE_W:0]   sum;
      logic [CODE_W-1:0] idx;
      sum = {1'b0, ptr} + (CODE_W+1)'(i);
      idx = (sum >= (CODE_W+1)'(N_REQ)) ? CODE_W'(sum - (CODE_W+1)'(N_REQ)) : sum[CODE_W-1:0];
      if (cand[idx]) begin
        if (!first_vld) begin
          first_vld = 1'b1;
          first_idx = idx;
        end else if (!second_vld) begin
          second_vld = 1'b1;
          second_idx = idx;
        end
      end
    end
  end
endmodule

// File: rtl/dual_grant_arbiter.sv
// Two-channel round-robin arbiter: per-channel IDLE/BUSY/GAP, hold limit, registered grants.
module dual_grant_arbiter
  import dual_priority_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_REQ-1:0]  i_req,
  output logic [N_REQ-1:0]  o_gnt_a,
  output logic [N_REQ-1:0]  o_gnt_b,
  output logic [CODE_W-1:0] o_code_a,
  output logic [CODE_W-1:0] o_code_b
);
  ch_state_e                  state_q [2];
  ch_state_e                  state_d [2];
  logic [1:0][CODE_W-1:0]     code_q, code_d;
  logic [1:0][7:0]            cnt_q, cnt_d;
  logic [1:0][N_REQ-1:0]      gnt_q;
  logic [CODE_W-1:0]          ptr_q, ptr_d;

  logic [N_REQ-1:0]  cand;
  logic              first_vld, second_vld;
  logic [CODE_W-1:0] first_idx, second_idx;

  // current holders stay masked on their release edge so they cannot hop channels
  assign cand = i_req & ~(code2onehot(code_q[0]) | code2onehot(code_q[1]));

  rr_dual_pick u_pick (
    .cand       (cand),
    .ptr        (ptr_q),
    .first_vld  (first_vld),
    .first_idx  (first_idx),
    .second_vld (second_vld),
    .second_idx (second_idx)
  );

  always_comb begin
    logic [1:0]        idle, forced;
    logic              granted;
    logic [CODE_W-1:0] last;
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idle    = '0;
    forced  = '0;
    granted = 1'b0;
    last    = '0;

    for (int c = 0; c < 2; c++) begin
      case (state_q[c])
        CH_BUSY: begin
          if ((i_req & code2onehot(code_q[c])) == '0 || cnt_q[c] == 8'(MAX_HOLD)) begin
            forced[c]  = ((i_req & code2onehot(code_q[c])) != '0);
            state_d[c] = CH_GAP;
            code_d[c]  = '0;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + 8'd1;
          end
        end
        CH_GAP:  state_d[c] = CH_IDLE;
        default: idle[c] = 1'b1;
      endcase
    end

    if (idle[0] && first_vld) begin
      state_d[0] = CH_BUSY;
      code_d[0]  = first_idx + 4'd1;
      cnt_d[0]   = 8'd1;
      granted    = 1'b1;
      last       = first_idx;
      if (idle[1] && second_vld) begin
        state_d[1] = CH_BUSY;
        code_d[1]  = second_idx + 4'd1;
        cnt_d[1]   = 8'd1;
        last       = second_idx;
      end
    end else if (idle[1] && first_vld) begin
      state_d[1] = CH_BUSY;
      code_d[1]  = first_idx + 4'd1;
      cnt_d[1]   = 8'd1;
      granted    = 1'b1;
      last       = first_idx;
    end

    // code == index+1, so the slot after a released holder is its code mod N_REQ
    if (granted)
      ptr_d = (last == CODE_W'(N_REQ - 1)) ? '0 : last + 4'd1;
    else if (forced[0])
      ptr_d = (code_q[0] == CODE_W'(N_REQ)) ? '0 : code_q[0];
    else if (forced[1])
      ptr_d = (code_q[1] == CODE_W'(N_REQ)) ? '0 : code_q[1];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int c = 0; c < 2; c++) state_q[c] <= CH_IDLE;
      code_q <= '0;
      cnt_q  <= '0;
      gnt_q  <= '0;
      ptr_q  <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        gnt_q[c]   <= code2onehot(code_d[c]);
      end
      code_q <= code_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
    end
  end

  assign o_gnt_a  = gnt_q[0];
  assign o_gnt_b  = gnt_q[1];
  assign o_code_a = code_q[0];
  assign o_code_b = code_q[1];
endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Randomized + directed bench for dual_grant_arbiter against a holder/queue reference model.
module tb_dual_grant_arbiter;
  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] req = '0;
  logic [11:0] gnt_a, gnt_b;
  logic [3:0]  code_a, code_b;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: holder index (-1 none), phase 0 idle / 1 busy / 2 gap
  int m_hold [2];
  int m_phase[2];
  int m_cnt  [2];
  int m_ptr;

  dual_grant_arbiter #(.MAX_HOLD(MH)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_req    (req),
    .o_gnt_a  (gnt_a),
    .o_gnt_b  (gnt_b),
    .o_code_a (code_a),
    .o_code_b (code_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [11:0] r, input logic rs);
    int cand[$];
    int forced, last;
    bit idle[2];
    if (rs) begin
      for (int c = 0; c < 2; c++) begin m_hold[c] = -1; m_phase[c] = 0; m_cnt[c] = 0; end
      m_ptr = 0;
      return;
    end
    for (int i = 0; i < 12; i++) begin
      int idx;
      idx = (m_ptr + i) % 12;
      if (r[idx] && idx != m_hold[0] && idx != m_hold[1]) cand.push_back(idx);
    end
    forced = -1;
    last   = -1;
    for (int c = 0; c < 2; c++) begin
      idle[c] = 0;
      if (m_phase[c] == 1) begin
        if (!r[m_hold[c]]) begin
          m_hold[c] = -1; m_phase[c] = 2; m_cnt[c] = 0;
        end else if (m_cnt[c] == MH) begin
          if (forced < 0) forced = m_hold[c];
          m_hold[c] = -1; m_phase[c] = 2; m_cnt[c] = 0;
        end else begin
          m_cnt[c]++;
        end
      end else if (m_phase[c] == 2) begin
        m_phase[c] = 0;
      end else begin
        idle[c] = 1;
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (idle[c] && cand.size() > 0) begin
        m_hold[c] = cand.pop_front(); m_phase[c] = 1; m_cnt[c] = 1; last = m_hold[c];
      end
    end
    if (last >= 0)        m_ptr = (last + 1) % 12;
    else if (forced >= 0) m_ptr = (forced + 1) % 12;
  endtask

  function automatic logic [11:0] exp_gnt(input int h);
    return (h < 0) ? 12'h000 : 12'(1 << h);
  endfunction

  function automatic logic [3:0] exp_code(input int h);
    return (h < 0) ? 4'd0 : 4'(h + 1);
  endfunction

  task automatic cycle(input logic [11:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    chk("m_code_a", 32'(code_a), 32'(exp_code(m_hold[0])));
    chk("m_code_b", 32'(code_b), 32'(exp_code(m_hold[1])));
    chk("m_gnt_a",  32'(gnt_a),  32'(exp_gnt(m_hold[0])));
    chk("m_gnt_b",  32'(gnt_b),  32'(exp_gnt(m_hold[1])));
    chk("m_ptr",    32'(dut.ptr_q), 32'(m_ptr));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code_a"}, 32'(code_a), 32'd0);
    chk({tag, "_code_b"}, 32'(code_b), 32'd0);
    chk({tag, "_gnt_a"},  32'(gnt_a),  32'd0);
    chk({tag, "_gnt_b"},  32'(gnt_b),  32'd0);
    chk({tag, "_ptr"},    32'(dut.ptr_q), 32'd0);
  endtask

  initial begin
    logic [11:0] r;
    // reset with no requests
    cycle(12'h000, 1'b1);
    cycle(12'h000, 1'b1);
    chk_all_zero("rst");

    // two hits from ptr 0
    cycle(12'h024, 1'b0);
    chk("p2_code_a", 32'(code_a), 32'd3);
    chk("p2_gnt_a",  32'(gnt_a),  32'h004);
    chk("p2_code_b", 32'(code_b), 32'd6);
    chk("p2_gnt_b",  32'(gnt_b),  32'h020);
    chk("p2_ptr",    32'(dut.ptr_q), 32'd6);

    // reset while both channels granted
    cycle(12'h024, 1'b1);
    chk_all_zero("rst_busy");

    // partial: A holds requester 3, B picks requester 4
    cycle(12'h008, 1'b0);
    chk("part_code_a0", 32'(code_a), 32'd4);
    chk("part_code_b0", 32'(code_b), 32'd0);
    cycle(12'h018, 1'b0);
    chk("part_code_b", 32'(code_b), 32'd5);
    chk("part_code_a", 32'(code_a), 32'd4);
    for (int k = 0; k < 6; k++) begin
      cycle(12'h018, 1'b0);
      chk("part_b_not_r3", 32'(code_b == 4'd4), 32'd0);
    end
    cycle(12'h000, 1'b1);

    // wrap: walk ptr to 10, release, then scan wraps 11 -> 1
    cycle(12'h200, 1'b0);
    chk("wrap_code_a0", 32'(code_a), 32'd10);
    cycle(12'h000, 1'b0);
    chk("wrap_rel", 32'(code_a), 32'd0);
    cycle(12'h000, 1'b0);
    chk("wrap_ptr10", 32'(dut.ptr_q), 32'd10);
    cycle(12'h802, 1'b0);
    chk("wrap_code_a", 32'(code_a), 32'd12);
    chk("wrap_gnt_a",  32'(gnt_a),  32'h800);
    chk("wrap_code_b", 32'(code_b), 32'd2);
    chk("wrap_gnt_b",  32'(gnt_b),  32'h002);
    chk("wrap_ptr",    32'(dut.ptr_q), 32'd2);
    cycle(12'h000, 1'b1);

    // hold limit: requester 0 on A for exactly MH cycles, two idle cycles, then requester 1
    for (int k = 1; k <= MH; k++) begin
      cycle(12'h003, 1'b0);
      chk("hold_gnt_a", 32'(gnt_a), 32'h001);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(12'h003, 1'b0);
      chk("hold_gap_a", 32'(gnt_a), 32'h000);
    end
    cycle(12'h003, 1'b0);
    chk("hold_regrant", 32'(code_a), 32'd2);
    cycle(12'h000, 1'b1);

    // voluntary release on A with requester 7 pending
    cycle(12'h024, 1'b0);
    cycle(12'h0A0, 1'b0);
    chk("rel_code_a", 32'(code_a), 32'd0);
    chk("rel_code_b", 32'(code_b), 32'd6);
    cycle(12'h0A0, 1'b0);
    chk("rel_gap_a", 32'(code_a), 32'd0);
    cycle(12'h0A0, 1'b0);
    chk("rel_regrant", 32'(code_a), 32'd8);
    chk("rel_regrant_gnt", 32'(gnt_a), 32'h080);
    cycle(12'h000, 1'b1);

    // random: request bits flip sparsely so holds persist; occasional reset
    r = 12'h000;
    for (int n = 0; n < 3000; n++) begin
      r = r ^ 12'($urandom & $urandom & $urandom);
      cycle(r, ($urandom_range(0, 63) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
